// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Function : 8N1 UART transmitter with a valid/ready byte input and a
//            registered, idle-high serial output.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD      = 9600,
    parameter int STOP_BITS = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] DIN,
    input  logic       DIN_VALID,
    output logic       DIN_READY,
    output logic       TX,
    output logic       BUSY
);

    localparam int c_clks_per_bit = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int c_cnt_w        = (c_clks_per_bit > 1) ? $clog2(c_clks_per_bit) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_clks_per_bit - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [2:0]         c_stop_last = 3'(STOP_BITS - 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_start = 2'd1;
    localparam logic [1:0] c_data  = 2'd2;
    localparam logic [1:0] c_stop  = 2'd3;

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_clk_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_tx;
    logic               w_accept;
    logic               w_bit_done;

    assign DIN_READY  = (r_state == c_idle);
    assign BUSY       = (r_state != c_idle);
    assign TX         = r_tx;
    assign w_accept   = DIN_VALID & DIN_READY;
    assign w_bit_done = (r_clk_cnt == c_cnt_last);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= c_idle;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                c_idle: begin
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    if (w_accept) begin
                        // Start bit is driven from the accept edge onward.
                        r_state <= c_start;
                        r_shift <= DIN;
                        r_tx    <= 1'b0;
                    end
                end
                c_start: begin
                    if (w_bit_done) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_state   <= c_data;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_clk_cnt <= r_clk_cnt + c_cnt_one;
                    end
                end
                c_data: begin
                    if (w_bit_done) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {1'b0, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state   <= c_stop;
                            r_bit_idx <= '0;
                            r_tx      <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + c_cnt_one;
                    end
                end
                c_stop: begin
                    // r_bit_idx is reused to count stop bits.
                    if (w_bit_done) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == c_stop_last) begin
                            r_state <= c_idle;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Function : Self-checking bench for uart_tx (one-stop and two-stop builds)
//            against a frame-position reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din1 = 8'h00;
    logic [7:0] din2 = 8'h00;
    logic       valid1 = 1'b0;
    logic       valid2 = 1'b0;
    logic       ready1, tx1, busy1;
    logic       ready2, tx2, busy2;

    uart_tx #(.CLK_FREQ(16), .BAUD(1), .STOP_BITS(1)) dut1 (
        .CLK(clk), .RESET(rst), .DIN(din1), .DIN_VALID(valid1),
        .DIN_READY(ready1), .TX(tx1), .BUSY(busy1)
    );

    uart_tx #(.CLK_FREQ(16), .BAUD(1), .STOP_BITS(2)) dut2 (
        .CLK(clk), .RESET(rst), .DIN(din2), .DIN_VALID(valid2),
        .DIN_READY(ready2), .TX(tx2), .BUSY(busy2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line level at cycle `pos` of a frame carrying byte b.
    function automatic logic exp_tx(input logic [7:0] b, input int pos);
        int k;
        k = pos / N;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    // Reference model: a frame is active for (9+STOP_BITS)*N cycles after an accept.
    bit         act1 = 0, act2 = 0;
    int         pos1 = 0, pos2 = 0;
    logic [7:0] b1 = 8'h00, b2 = 8'h00;
    int         acc1 = 0, acc2 = 0, acc1_cyc = 0, mcyc = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            act1 = 0;
            act2 = 0;
        end else begin
            mcyc++;
            if (act1) begin
                pos1++;
                if (pos1 == 10 * N) act1 = 0;
            end else if (valid1) begin
                act1 = 1; pos1 = 0; b1 = din1; acc1++; acc1_cyc = mcyc;
            end
            if (act2) begin
                pos2++;
                if (pos2 == 11 * N) act2 = 0;
            end else if (valid2) begin
                act2 = 1; pos2 = 0; b2 = din2; acc2++;
            end
        end
    end

    always @(negedge clk) begin
        check("tx1",    tx1,    act1 ? exp_tx(b1, pos1) : 1'b1);
        check("ready1", ready1, !act1);
        check("busy1",  busy1,  act1);
        check("tx2",    tx2,    act2 ? exp_tx(b2, pos2) : 1'b1);
        check("ready2", ready2, !act2);
        check("busy2",  busy2,  act2);
    end

    // Mid-bit sampling decoder on dut1's line.
    bit         dec_en = 0;
    logic [7:0] rxq[$];

    initial begin
        logic [7:0] rb;
        forever begin
            @(negedge clk);
            if (dec_en && tx1 === 1'b0) begin
                repeat (N / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (N) @(negedge clk);
                    rb[i] = tx1;
                end
                repeat (N) @(negedge clk);
                check("dec_stop", tx1, 1'b1);
                rxq.push_back(rb);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input int which, input logic [7:0] b, input bit hold);
        int  a0;
        bit  got;
        got = 0;
        if (which == 1) begin din1 = b; valid1 = 1'b1; a0 = acc1; end
        else            begin din2 = b; valid2 = 1'b1; a0 = acc2; end
        for (int i = 0; i < 500; i++) begin
            tick();
            if ((which == 1 ? acc1 : acc2) != a0) begin got = 1; break; end
        end
        if (!got) check("accept_timeout", 0, 1);
        if (!hold) begin
            if (which == 1) valid1 = 1'b0; else valid2 = 1'b0;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500 && (act1 || act2); i++) tick();
        if (act1 || act2) check("idle_timeout", 0, 1);
        tick();
    endtask

    initial begin
        int t1;
        logic [7:0] v;

        repeat (3) tick();
        check("rst_tx", tx1, 1'b1);
        check("rst_ready", ready1, 1'b1);
        check("rst_busy", busy1, 1'b0);
        rst = 1'b0;
        step(100);
        check("idle_tx", tx1, 1'b1);

        // 0x55: start, 1,0,1,... then stop; ready low for 160 cycles.
        send(1, 8'h55, 0);
        step(8);  check("x55_start", tx1, 1'b0);
        step(16); check("x55_b0", tx1, 1'b1);
        step(16); check("x55_b1", tx1, 1'b0);
        step(16); check("x55_b2", tx1, 1'b1);
        step(96); check("x55_stop", tx1, 1'b1);
        check("x55_ready_stop", ready1, 1'b0);
        step(7);  check("x55_ready_159", ready1, 1'b0);
        step(1);  check("x55_ready_160", ready1, 1'b1);
        check("x55_busy_160", busy1, 1'b0);
        wait_idle();

        // Back-to-back with valid held.
        dec_en = 1;
        send(1, 8'hA3, 1);
        t1 = acc1_cyc;
        send(1, 8'h0F, 0);
        check("b2b_spacing", acc1_cyc - t1, 161);
        wait_idle();
        dec_en = 0;
        check("dec_count", rxq.size(), 2);
        v = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx; check("dec_a3", v, 8'hA3);
        v = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx; check("dec_0f", v, 8'h0F);

        // DIN changes right after accept.
        send(1, 8'h00, 0);
        din1 = 8'hFF;
        step(24);
        for (int k = 0; k < 8; k++) begin
            check("latched_bit", tx1, 1'b0);
            step(16);
        end
        wait_idle();

        // Reset mid-frame, then a clean frame.
        send(1, 8'h00, 0);
        step(70);
        rst = 1'b1;
        #1;
        check("abort_tx", tx1, 1'b1);
        check("abort_busy", busy1, 1'b0);
        repeat (3) tick();
        rst = 1'b0;
        step(200);
        check("abort_no_residual", tx1, 1'b1);
        dec_en = 1;
        send(1, 8'h81, 0);
        wait_idle();
        dec_en = 0;
        v = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx; check("dec_81", v, 8'h81);

        // Two stop bits: 176-cycle frame.
        send(2, 8'h00, 0);
        step(150); check("s2_stop_early", tx2, 1'b1);
        check("s2_ready_150", ready2, 1'b0);
        step(25);  check("s2_stop_late", tx2, 1'b1);
        check("s2_ready_175", ready2, 1'b0);
        step(1);   check("s2_ready_176", ready2, 1'b1);
        wait_idle();

        // Randomized valid/data on both builds.
        for (int i = 0; i < 3000; i++) begin
            tick();
            valid1 = ($urandom_range(0, 3) == 0);
            din1   = 8'($urandom);
            valid2 = ($urandom_range(0, 3) == 0);
            din2   = 8'($urandom);
        end
        valid1 = 1'b0;
        valid2 = 1'b0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
